fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Instruction fetch/execute sequencer that sits directly upstream of the 5-bit program counter.
//   Generates the counter's load, increment and load-data.
//   Runs the memory read/write handshake and holds the instruction register.
//   Issues single-cycle control pulses to the accumulator/ALU stage.
//   Instruction word is {opcode[2:0], addr[4:0]}.
// PARAMETERS
//   OPW   3   opcode width
//   AW    5   address field width; must match the program counter width
//   DW    8   memory data width; must equal OPW+AW
// PORTS
//   clk        in   1    system clock; all state changes on rising edge
//   rst        in   1    asynchronous reset, active-high
//   mem_data   in   DW   memory read data; valid when mem_rdy=1
//   mem_rdy    in   1    memory completes the pending read or write this cycle
//   zero       in   1    accumulator-is-zero flag, sampled in DECODE
//   resume     in   1    leaves HALT
//   mem_rd     out  1    read request, held until mem_rdy
//   mem_wr     out  1    write request (accumulator to ir_addr), held until mem_rdy
//   addr_sel   out  1    0: memory address = PC; 1: memory address = ir_addr
//   pc_inc     out  1    program counter +1 this edge (modulo 2**AW)
//   pc_load    out  1    program counter <= pc_data this edge; priority over pc_inc
//   pc_data    out  AW   jump target; always equals ir_addr
//   ir_opcode  out  OPW  latched opcode
//   ir_addr    out  AW   latched address field
//   opnd       out  DW   latched operand
//   acc_ld     out  1    accumulator <= ALU(ir_opcode, acc, opnd) this edge
//   halted     out  1    1 while in HALT
// BEHAVIOUR
//   Opcodes:
//     HLT=000  SKZ=001  ADD=010  AND=011  XOR=100  LDA=101  STO=110  JMP=111.
//   Output style:
//     All control outputs are Moore: decoded from state only.
//     At most one of pc_inc/pc_load is high in any cycle.
//   Reset:
//     state=IDLE; ir_opcode, ir_addr and opnd = 0.
//     All control outputs 0.
//     Reset asserted mid-operation aborts the access immediately; mem_rd/mem_wr drop asynchronously.
//   States and transitions:
//     IDLE:   no outputs; always -> FETCH.
//     FETCH:  mem_rd=1, addr_sel=0.
//             mem_rdy=0: stay. mem_rdy=1: IR <= mem_data, -> DECODE.
//     DECODE: pc_inc=1 (exactly one cycle). Next state by opcode:
//             HLT -> HALT; JMP -> JUMP; STO -> STORE; ADD/AND/XOR/LDA -> OPRD.
//             SKZ with zero=1 -> SKIP; SKZ with zero=0 -> FETCH.
//     SKIP:   pc_inc=1; -> FETCH.
//     JUMP:   pc_load=1; -> FETCH.
//     OPRD:   mem_rd=1, addr_sel=1.
//             mem_rdy=0: stay. mem_rdy=1: opnd <= mem_data, -> ALU.
//     ALU:    acc_ld=1; -> FETCH.
//     STORE:  mem_wr=1, addr_sel=1.
//             mem_rdy=0: stay. mem_rdy=1: -> FETCH.
//     HALT:   halted=1.
//             resume=1: -> FETCH, fetching from the already-incremented PC. resume=0: stay.
//   Handshake and cycle counts:
//     mem_rdy is ignored outside FETCH/OPRD/STORE.
//     Zero-wait memory (mem_rdy tied high) gives these cycles per instruction:
//       JMP/SKZ-taken: 3. SKZ-not-taken: 2. STO: 3. ALU ops: 4.
//   Boundary cases:
//     PC wrap 31 -> 0 is owned by the counter; fetch_ctrl places no restriction on it.
//     JMP to the current address is legal and loops.
//     SKZ at PC=31 skips to address 1.
//     resume asserted outside HALT has no effect.
//     Unknown/X opcode never occurs: all 8 codes are decoded.
// TESTING
//   1. Reset.
//      Stimulus: rst=1 mid-FETCH.
//      Response: mem_rd=0 and pc_inc=0 immediately. First cycle after release is IDLE; mem_rd=1 the cycle after.
//   2. JMP.
//      Stimulus: mem_data=8'hFD (JMP 5'h1D), mem_rdy=1.
//      Response: pc_inc one cycle, then pc_load=1 with pc_data=5'h1D, then FETCH.
//   3. SKZ.
//      Stimulus: mem_data=8'h20, zero=1.
//      Response: pc_inc in DECODE and in SKIP (two increments). Repeat with zero=0: one increment, then FETCH.
//   4. ADD with wait states.
//      Stimulus: mem_data=8'h43, mem_rdy low for 3 cycles in OPRD, then operand 8'h5A.
//      Response: addr_sel=1 and ir_addr=5'h03 held throughout; opnd=8'h5A; acc_ld high exactly one cycle.
//   5. STO.
//      Stimulus: mem_data=8'hDF.
//      Response: mem_wr=1 with addr_sel=1 and ir_addr=5'h1F until mem_rdy; mem_rd=0 throughout.
//   6. HLT.
//      Stimulus: mem_data=8'h00.
//      Response: halted=1 with no mem_rd for 10 cycles; resume=1 gives FETCH next cycle with addr_sel=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Fetch/decode/execute sequencer for a small accumulator machine. It drives
//   the program counter (increment / load), runs the memory read/write
//   handshake, holds the instruction register and operand latch, and pulses
//   the accumulator load for ALU-class instructions.
//
//   Instruction word: {opcode[OPW-1:0], addr[AW-1:0]}.
//   Opcodes: HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   mem_data   in   memory read data, valid when mem_rdy=1
//   mem_rdy    in   memory completes the pending access this cycle
//   zero       in   accumulator-is-zero flag (used by SKZ in DECODE)
//   resume     in   leaves HALT
//   mem_rd     out  read request, held until mem_rdy
//   mem_wr     out  write request (accumulator to ir_addr), held until mem_rdy
//   addr_sel   out  0: memory address = PC, 1: memory address = ir_addr
//   pc_inc     out  PC <= PC + 1 on this edge
//   pc_load    out  PC <= pc_data on this edge
//   pc_data    out  jump target (always ir_addr)
//   ir_opcode  out  latched opcode
//   ir_addr    out  latched address field
//   opnd       out  latched operand
//   acc_ld     out  accumulator <= ALU(ir_opcode, acc, opnd) on this edge
//   halted     out  1 while in HALT
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int OPW = 3,
    parameter int AW  = 5,
    parameter int DW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  mem_data,
    input  logic           mem_rdy,
    input  logic           zero,
    input  logic           resume,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           addr_sel,
    output logic           pc_inc,
    output logic           pc_load,
    output logic [AW-1:0]  pc_data,
    output logic [OPW-1:0] ir_opcode,
    output logic [AW-1:0]  ir_addr,
    output logic [DW-1:0]  opnd,
    output logic           acc_ld,
    output logic           halted
);

    localparam logic [OPW-1:0] OP_HLT = 3'b000;
    localparam logic [OPW-1:0] OP_SKZ = 3'b001;
    localparam logic [OPW-1:0] OP_ADD = 3'b010;
    localparam logic [OPW-1:0] OP_AND = 3'b011;
    localparam logic [OPW-1:0] OP_XOR = 3'b100;
    localparam logic [OPW-1:0] OP_LDA = 3'b101;
    localparam logic [OPW-1:0] OP_STO = 3'b110;
    localparam logic [OPW-1:0] OP_JMP = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SKIP,
        S_JUMP,
        S_OPRD,
        S_ALU,
        S_STORE,
        S_HALT
    } state_t;

    state_t state;
    state_t next_state;

    // State register. Outputs are decoded from state alone, so the async
    // reset drops any pending mem_rd/mem_wr without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Instruction register and operand latch capture only on a completed read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_opcode <= '0;
            ir_addr   <= '0;
            opnd      <= '0;
        end else begin
            if (state == S_FETCH && mem_rdy) begin
                ir_opcode <= mem_data[DW-1:AW];
                ir_addr   <= mem_data[AW-1:0];
            end
            if (state == S_OPRD && mem_rdy) begin
                opnd <= mem_data;
            end
        end
    end

    assign pc_data = ir_addr;

    always_comb begin
        next_state = state;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        addr_sel   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        acc_ld     = 1'b0;
        halted     = 1'b0;

        case (state)
            S_IDLE: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_rdy) next_state = S_DECODE;
            end
            S_DECODE: begin
                // PC advances past the instruction word here, so HALT/resume
                // and SKZ both continue from the incremented address.
                pc_inc = 1'b1;
                case (ir_opcode)
                    OP_HLT: next_state = S_HALT;
                    OP_SKZ: next_state = zero ? S_SKIP : S_FETCH;
                    OP_ADD,
                    OP_AND,
                    OP_XOR,
                    OP_LDA: next_state = S_OPRD;
                    OP_STO: next_state = S_STORE;
                    OP_JMP: next_state = S_JUMP;
                    default: next_state = S_HALT;
                endcase
            end
            S_SKIP: begin
                pc_inc     = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_load    = 1'b1;
                next_state = S_FETCH;
            end
            S_OPRD: begin
                mem_rd   = 1'b1;
                addr_sel = 1'b1;
                if (mem_rdy) next_state = S_ALU;
            end
            S_ALU: begin
                acc_ld     = 1'b1;
                next_state = S_FETCH;
            end
            S_STORE: begin
                mem_wr   = 1'b1;
                addr_sel = 1'b1;
                if (mem_rdy) next_state = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) next_state = S_FETCH;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Directed stimulus for fetch_ctrl. Each stimulus step drives one cycle of
//   inputs and pushes the hand-computed outputs expected during that cycle
//   into a queue; a monitor pops and compares on the falling edge.
//   Control vector order: {mem_rd, mem_wr, addr_sel, pc_inc, pc_load, acc_ld, halted}
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_data;
    logic       mem_rdy;
    logic       zero;
    logic       resume;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic       pc_inc;
    logic       pc_load;
    logic [4:0] pc_data;
    logic [2:0] ir_opcode;
    logic [4:0] ir_addr;
    logic [7:0] opnd;
    logic       acc_ld;
    logic       halted;

    fetch_ctrl #(.OPW(3), .AW(5), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_data  (mem_data),
        .mem_rdy   (mem_rdy),
        .zero      (zero),
        .resume    (resume),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .addr_sel  (addr_sel),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_data   (pc_data),
        .ir_opcode (ir_opcode),
        .ir_addr   (ir_addr),
        .opnd      (opnd),
        .acc_ld    (acc_ld),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_FETCH  = 7'b1000000;
    localparam logic [6:0] C_DECODE = 7'b0001000;
    localparam logic [6:0] C_SKIP   = 7'b0001000;
    localparam logic [6:0] C_JUMP   = 7'b0000100;
    localparam logic [6:0] C_OPRD   = 7'b1010000;
    localparam logic [6:0] C_ALU    = 7'b0000010;
    localparam logic [6:0] C_STORE  = 7'b0110000;
    localparam logic [6:0] C_HALT   = 7'b0000001;

    typedef struct {
        string      name;
        logic [6:0] ctrl;
        logic [7:0] ir;
        logic [7:0] op;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // One cycle: drive inputs just after the rising edge, and queue the
    // outputs the DUT must show during this cycle.
    task automatic cyc(input string name, input logic r, input logic rdy,
                       input logic [7:0] data, input logic z, input logic res,
                       input logic [6:0] ctrl, input logic [7:0] ir,
                       input logic [7:0] op);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        mem_rdy  = rdy;
        mem_data = data;
        zero     = z;
        resume   = res;
        e.name = name;
        e.ctrl = ctrl;
        e.ir   = ir;
        e.op   = op;
        exp_q.push_back(e);
    endtask

    // Monitor: compares control, IR, operand and pc_data (which must mirror ir_addr).
    initial begin
        exp_t       e;
        logic [27:0] act;
        logic [27:0] req;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {mem_rd, mem_wr, addr_sel, pc_inc, pc_load, acc_ld, halted,
                       ir_opcode, ir_addr, opnd, pc_data};
                req = {e.ctrl, e.ir, e.op, e.ir[4:0]};
                n_checks++;
                if (act === req) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got ctrl=%b ir=%h opnd=%h pc_data=%h, want ctrl=%b ir=%h opnd=%h pc_data=%h",
                             e.name, act[27:21], act[20:13], act[12:5], act[4:0],
                             req[27:21], req[20:13], req[12:5], req[4:0]);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        mem_rdy  = 1'b0;
        mem_data = 8'h00;
        zero     = 1'b0;
        resume   = 1'b0;

        //  name             rst  rdy  data   z    res  ctrl      ir     op
        cyc("reset_state",   1, 0, 8'h00, 0, 0, C_IDLE,   8'h00, 8'h00);
        cyc("release_idle",  0, 0, 8'h00, 0, 0, C_IDLE,   8'h00, 8'h00);
        cyc("fetch_wait",    0, 0, 8'h00, 0, 1, C_FETCH,  8'h00, 8'h00);
        cyc("resume_no_eff", 0, 0, 8'h00, 0, 0, C_FETCH,  8'h00, 8'h00);
        // Reset mid-FETCH: outputs must drop before the next clock edge.
        cyc("rst_mid_fetch", 1, 0, 8'h00, 0, 0, C_IDLE,   8'h00, 8'h00);
        cyc("idle_after",    0, 0, 8'h00, 0, 0, C_IDLE,   8'h00, 8'h00);
        // JMP 1D
        cyc("jmp_fetch",     0, 1, 8'hFD, 0, 0, C_FETCH,  8'h00, 8'h00);
        cyc("jmp_decode",    0, 1, 8'h00, 0, 0, C_DECODE, 8'hFD, 8'h00);
        cyc("jmp_load",      0, 0, 8'h00, 0, 0, C_JUMP,   8'hFD, 8'h00);
        // SKZ taken
        cyc("skz1_fetch",    0, 1, 8'h20, 0, 0, C_FETCH,  8'hFD, 8'h00);
        cyc("skz1_decode",   0, 1, 8'h00, 1, 0, C_DECODE, 8'h20, 8'h00);
        cyc("skz1_skip",     0, 0, 8'h00, 0, 0, C_SKIP,   8'h20, 8'h00);
        // SKZ not taken
        cyc("skz0_fetch",    0, 1, 8'h20, 0, 0, C_FETCH,  8'h20, 8'h00);
        cyc("skz0_decode",   0, 0, 8'h00, 0, 0, C_DECODE, 8'h20, 8'h00);
        // ADD 03 with three wait states on the operand read
        cyc("add_fetch",     0, 1, 8'h43, 0, 0, C_FETCH,  8'h20, 8'h00);
        cyc("add_decode",    0, 0, 8'h00, 0, 0, C_DECODE, 8'h43, 8'h00);
        cyc("add_oprd_w1",   0, 0, 8'hEE, 0, 0, C_OPRD,   8'h43, 8'h00);
        cyc("add_oprd_w2",   0, 0, 8'hEE, 0, 0, C_OPRD,   8'h43, 8'h00);
        cyc("add_oprd_w3",   0, 0, 8'hEE, 0, 0, C_OPRD,   8'h43, 8'h00);
        cyc("add_oprd_rdy",  0, 1, 8'h5A, 0, 0, C_OPRD,   8'h43, 8'h00);
        cyc("add_alu",       0, 0, 8'h00, 0, 0, C_ALU,    8'h43, 8'h5A);
        // STO 1F with one wait state
        cyc("sto_fetch",     0, 1, 8'hDF, 0, 0, C_FETCH,  8'h43, 8'h5A);
        cyc("sto_decode",    0, 0, 8'h00, 0, 0, C_DECODE, 8'hDF, 8'h5A);
        cyc("sto_wait",      0, 0, 8'h00, 0, 0, C_STORE,  8'hDF, 8'h5A);
        cyc("sto_rdy",       0, 1, 8'h00, 0, 0, C_STORE,  8'hDF, 8'h5A);
        // HLT: ten idle halted cycles, then resume
        cyc("hlt_fetch",     0, 1, 8'h00, 0, 0, C_FETCH,  8'hDF, 8'h5A);
        cyc("hlt_decode",    0, 1, 8'h00, 0, 0, C_DECODE, 8'h00, 8'h5A);
        for (int i = 0; i < 10; i++) begin
            cyc("hlt_hold",  0, 1, 8'hFF, 0, 0, C_HALT,   8'h00, 8'h5A);
        end
        cyc("hlt_resume",    0, 0, 8'h00, 0, 1, C_HALT,   8'h00, 8'h5A);
        cyc("resume_fetch",  0, 0, 8'h00, 0, 0, C_FETCH,  8'h00, 8'h5A);
        // Final reset clears the operand latch as well.
        cyc("rst_clears",    1, 0, 8'h00, 0, 0, C_IDLE,   8'h00, 8'h00);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
